spi_frame_slave: RTL and testbench

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_pkg.sv | 14 +
 rtl/sync2.sv | 23 ++
 rtl/spi_frame_slave.sv | 126 ++++++++++++
 tb/tb_spi_frame_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI frame slave.
package spi_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam int unsigned DEFAULT_WORD_W    = 32;
    localparam int unsigned DEFAULT_NUM_WORDS = 2;

    function automatic int unsigned frame_bits(input int unsigned word_w,
                                               input int unsigned num_words);
        return word_w * num_words;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave that shifts fixed-length frames, double-buffers received frames and
// releases them to rx_data on a commit strobe.
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W      = DEFAULT_WORD_W,
    parameter int unsigned NUM_WORDS   = DEFAULT_NUM_WORDS,
    parameter int unsigned SAMPLE_RISE = 0,
    localparam int unsigned FRAME_BITS = frame_bits(WORD_W, NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  sdo,
    input  logic                  commit,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  sdi,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    // sck idles on the level from which its first transition is a sample edge.
    localparam bit SCK_IDLE = (SAMPLE_RISE == 0);

    logic sck_s, cs_s, sdo_s, commit_s;
    logic sck_prev, cs_prev, commit_prev;
    logic sample_edge, shift_edge, cs_fall, cs_rise, commit_rise;

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] rx_sr, tx_sr, pending, rx_next;
    logic                  pending_valid;

    sync2 #(.RESET_VAL(SCK_IDLE)) u_sync_sck (.clk(clk), .reset(reset), .d(sck),    .q(sck_s));
    sync2 #(.RESET_VAL(1'b1))     u_sync_cs  (.clk(clk), .reset(reset), .d(cs_n),   .q(cs_s));
    sync2 #(.RESET_VAL(1'b0))     u_sync_sdo (.clk(clk), .reset(reset), .d(sdo),    .q(sdo_s));
    sync2 #(.RESET_VAL(1'b0))     u_sync_cmt (.clk(clk), .reset(reset), .d(commit), .q(commit_s));

    always_comb begin
        sample_edge = (SAMPLE_RISE != 0) ? (sck_s & ~sck_prev) : (~sck_s & sck_prev);
        shift_edge  = (SAMPLE_RISE != 0) ? (~sck_s & sck_prev) : (sck_s & ~sck_prev);
        cs_fall     = cs_prev & ~cs_s;
        cs_rise     = ~cs_prev & cs_s;
        commit_rise = commit_s & ~commit_prev;
        rx_next     = {rx_sr[FRAME_BITS-2:0], sdo_s};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_prev      <= SCK_IDLE;
            cs_prev       <= 1'b1;
            commit_prev   <= 1'b0;
            state         <= StIdle;
            cnt           <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            sdi           <= 1'b0;
            rx_data       <= '0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            sck_prev    <= sck_s;
            cs_prev     <= cs_s;
            commit_prev <= commit_s;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;

            // Commit reads the pre-update buffer; a same-cycle completion re-arms it below.
            if (commit_rise && pending_valid) begin
                rx_data       <= pending;
                pending_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    sdi <= 1'b0;
                    if (cs_fall) begin
                        state <= StShift;
                        tx_sr <= tx_data;
                        sdi   <= tx_data[FRAME_BITS-1];
                        cnt   <= '0;
                        rx_sr <= '0;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        state     <= StIdle;
                        sdi       <= 1'b0;
                        frame_err <= (cnt != '0);
                    end else if (sample_edge) begin
                        rx_sr <= rx_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            pending       <= rx_next;
                            pending_valid <= 1'b1;
                            frame_done    <= 1'b1;
                            overrun       <= pending_valid & ~commit_rise;
                            state         <= StDone;
                            sdi           <= 1'b0;
                        end
                    end else if (shift_edge) begin
                        tx_sr <= tx_sr << 1;
                        sdi   <= tx_sr[FRAME_BITS-2];
                    end
                end
                StDone: begin
                    sdi <= 1'b0;
                    if (cs_rise) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed and randomized frames against a frame-level model of the slave.
module tb_spi_frame_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b1, cs_n = 1'b1, sdo = 1'b0, commit = 1'b0;
    logic [63:0] tx_data = '0;
    logic        sdi, frame_done, overrun, frame_err;
    logic [63:0] rx_data;

    logic        sck2 = 1'b0, cs2_n = 1'b1, sdo2 = 1'b0, commit2 = 1'b0;
    logic [23:0] tx2 = '0;
    logic        sdi2, done2, ovr2, err2;
    logic [23:0] rx2;

    int checks = 0, errors = 0;
    int n_done = 0, n_ovr = 0, n_err = 0, n_done2 = 0;

    logic [63:0] model_rx = '0, model_pending = '0;
    bit          model_pv = 1'b0;

    always #5 clk = ~clk;

    spi_frame_slave #(.WORD_W(32), .NUM_WORDS(2), .SAMPLE_RISE(0)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdo(sdo), .commit(commit),
        .tx_data(tx_data), .sdi(sdi), .rx_data(rx_data), .frame_done(frame_done),
        .overrun(overrun), .frame_err(frame_err)
    );

    spi_frame_slave #(.WORD_W(8), .NUM_WORDS(3), .SAMPLE_RISE(1)) dut2 (
        .clk(clk), .reset(reset), .sck(sck2), .cs_n(cs2_n), .sdo(sdo2), .commit(commit2),
        .tx_data(tx2), .sdi(sdi2), .rx_data(rx2), .frame_done(done2),
        .overrun(ovr2), .frame_err(err2)
    );

    always @(posedge clk) begin
        if (frame_done) n_done++;
        if (overrun)    n_ovr++;
        if (frame_err)  n_err++;
        if (done2)      n_done2++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Master side: present sdo, capture sdi just before each falling (sample) edge.
    task automatic send1(input logic [63:0] data, input int nbits, input bit raise_cs,
                         input bit commit_last, output logic [63:0] got);
        got  = '0;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdo = data[63-i];
            repeat (5) @(negedge clk);
            got[63-i] = sdi;
            sck = 1'b0;
            if (commit_last && i == nbits - 1) commit = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b1;
        end
        repeat (5) @(negedge clk);
        commit = 1'b0;
        if (raise_cs) begin
            cs_n = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic send2(input logic [23:0] data, output logic [23:0] got);
        got   = '0;
        cs2_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            sdo2 = data[23-i];
            repeat (5) @(negedge clk);
            got[23-i] = sdi2;
            sck2 = 1'b1;
            repeat (5) @(negedge clk);
            sck2 = 1'b0;
        end
        repeat (5) @(negedge clk);
        cs2_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        repeat (5) @(negedge clk);
        commit = 1'b0;
        repeat (5) @(negedge clk);
        if (model_pv) begin
            model_rx = model_pending;
            model_pv = 1'b0;
        end
    endtask

    // Frame landing in the model; returns whether an overrun is expected.
    task automatic model_frame(input logic [63:0] frame, input bit same_commit,
                               output bit exp_ovr);
        if (same_commit && model_pv) begin
            model_rx = model_pending;
            model_pv = 1'b0;
        end
        exp_ovr       = model_pv;
        model_pending = frame;
        model_pv      = 1'b1;
    endtask

    initial begin
        logic [63:0] got, a, b, c;
        logic [23:0] got2;
        int d0, o0, e0;
        bit exp_ovr;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_rx", rx_data, 64'h0);
        check("reset_sdi", {63'h0, sdi}, 64'h0);
        check("reset_pulses", {32'(n_done), 32'(n_ovr + n_err)}, 64'h0);
        check("reset_rx2", {40'h0, rx2}, 64'h0);

        // Basic frame plus commit
        tx_data = 64'hA5A5A5A5_5A5A5A5A;
        d0 = n_done;
        send1(64'hDEADBEEF_01234567, 64, 1'b1, 1'b0, got);
        model_frame(64'hDEADBEEF_01234567, 1'b0, exp_ovr);
        check("basic_sdi", got, 64'hA5A5A5A5_5A5A5A5A);
        check("basic_done", 64'(n_done - d0), 64'd1);
        check("basic_rx_precommit", rx_data, model_rx);
        pulse_commit();
        check("basic_rx", rx_data, 64'hDEADBEEF_01234567);

        // Two frames without commit -> overrun on the second
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        o0 = n_ovr;
        send1(a, 64, 1'b1, 1'b0, got);
        model_frame(a, 1'b0, exp_ovr);
        check("ovr_after_a", 64'(n_ovr - o0), 64'(exp_ovr));
        send1(b, 64, 1'b1, 1'b0, got);
        model_frame(b, 1'b0, exp_ovr);
        check("ovr_after_b", 64'(n_ovr - o0), 64'd1);
        pulse_commit();
        check("ovr_rx", rx_data, b);

        // Partial frame leaves the pending buffer alone
        c = {$urandom(), $urandom()};
        send1(c, 64, 1'b1, 1'b0, got);
        model_frame(c, 1'b0, exp_ovr);
        d0 = n_done; e0 = n_err;
        send1({$urandom(), $urandom()}, 17, 1'b1, 1'b0, got);
        check("partial_err", 64'(n_err - e0), 64'd1);
        check("partial_done", 64'(n_done - d0), 64'd0);
        check("partial_rx", rx_data, model_rx);
        pulse_commit();
        check("partial_pending", rx_data, c);

        // Completion and commit detected in the same cycle
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        send1(a, 64, 1'b1, 1'b0, got);
        model_frame(a, 1'b0, exp_ovr);
        o0 = n_ovr;
        send1(b, 64, 1'b1, 1'b1, got);
        model_frame(b, 1'b1, exp_ovr);
        check("coinc_rx", rx_data, a);
        check("coinc_ovr", 64'(n_ovr - o0), 64'd0);
        pulse_commit();
        check("coinc_pending", rx_data, b);

        // Reset mid-frame
        e0 = n_err;
        send1({$urandom(), $urandom()}, 40, 1'b0, 1'b0, got);
        reset = 1'b1;
        cs_n  = 1'b1;
        sck   = 1'b1;
        repeat (3) @(negedge clk);
        check("inreset_rx", rx_data, 64'h0);
        check("inreset_outs", {60'h0, sdi, frame_done, overrun, frame_err}, 64'h0);
        reset = 1'b0;
        model_rx = '0; model_pending = '0; model_pv = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_no_err", 64'(n_err - e0), 64'd0);
        send1(64'h0000000F_F0000000, 64, 1'b1, 1'b0, got);
        model_frame(64'h0000000F_F0000000, 1'b0, exp_ovr);
        pulse_commit();
        check("postreset_rx", rx_data, 64'h0000000F_F0000000);

        // Randomized frames with random commits
        for (int k = 0; k < 4; k++) begin
            tx_data = {$urandom(), $urandom()};
            a = {$urandom(), $urandom()};
            d0 = n_done; o0 = n_ovr;
            send1(a, 64, 1'b1, 1'b0, got);
            model_frame(a, 1'b0, exp_ovr);
            check("rand_sdi", got, tx_data);
            check("rand_done", 64'(n_done - d0), 64'd1);
            check("rand_ovr", 64'(n_ovr - o0), 64'(exp_ovr));
            if ($urandom_range(0, 1) == 1) pulse_commit();
            check("rand_rx", rx_data, model_rx);
        end

        // Rising-edge sampling variant
        tx2 = 24'($urandom());
        send2(24'h3CC37E, got2);
        check("mode1_sdi", {40'h0, got2}, {40'h0, tx2});
        check("mode1_done", 64'(n_done2), 64'd1);
        commit2 = 1'b1;
        repeat (5) @(negedge clk);
        commit2 = 1'b0;
        repeat (5) @(negedge clk);
        check("mode1_rx", {40'h0, rx2}, 64'h3CC37E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
